// File: rtl/frontpanel_spi_responder_pkg.sv
// Shared definitions for the front-panel SPI responder.
// Contents:
//   spi_state_t      - transaction state (idle, selected between bytes, shifting a byte)
//   SYNC_STAGES_DEF  - default synchronizer depth for sck, cs_n and mosi
//   IDLE_BYTE_DEF    - default byte returned on miso when nothing is queued
//   BYTE_LAST_BIT    - bit-counter value at the eighth (last) bit of a byte
package frontpanel_spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SELECTED  = 2'd1,
    ST_SHIFTING  = 2'd2
  } spi_state_t;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam logic [7:0]  IDLE_BYTE_DEF   = 8'h00;
  localparam logic [2:0]  BYTE_LAST_BIT   = 3'd7;

endpackage

// File: rtl/frontpanel_spi_sync.sv
// Multi-flop synchronizer with registered edge detection for one asynchronous
// SPI input.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset (clears all flops)
//   i_async   - raw asynchronous input
//   o_level   - synchronized level (last synchronizer stage)
//   o_rise    - one-cycle strobe, registered the cycle after o_level goes 0->1
//   o_fall    - one-cycle strobe, registered the cycle after o_level goes 1->0
// STAGES must be at least 2.
module frontpanel_spi_sync
  import frontpanel_spi_responder_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/frontpanel_spi_responder.sv
// SPI mode-0 slave responder for the front panel. Everything runs on clk; the
// host's sck/cs_n/mosi are oversampled (clk must be >= 8x sck).
// Ports:
//   clk, rst                 - system clock, asynchronous active-high reset
//   spi_sck/spi_cs_n/spi_mosi- host SPI inputs (asynchronous)
//   spi_miso                 - device data out, 0 while deselected
//   rx_data_valid/rx_data    - one-cycle strobe with the received byte
//   rx_first                 - qualifies rx_data_valid: first byte after select
//   tx_data_valid/tx_data    - load a byte into the transmit holding register
//   tx_ready                 - holding register empty
//   tx_underrun              - strobe: a byte slot started with nothing queued
//   cs_start/cs_end          - strobes on synchronized cs_n fall/rise
module frontpanel_spi_responder
  import frontpanel_spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       rx_data_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       cs_start,
  output logic       cs_end
);

  logic w_sck_rise, w_sck_fall, w_cs_level, w_cs_start, w_cs_end, w_mosi;
  // Edge/level outputs that this design has no use for on a given input.
  logic w_sck_level_unused, w_mosi_rise_unused, w_mosi_fall_unused;

  frontpanel_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .i_async(spi_sck),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  frontpanel_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(spi_cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_end), .o_fall(w_cs_start)
  );

  frontpanel_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_t r_state, w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_rx_data, r_tx_shift, r_hold_data;
  logic       r_hold_full, r_load_pending, r_first_byte;
  logic       r_rx_valid, r_rx_first, r_tx_underrun;

  logic w_active, w_rise_act, w_fall_act, w_byte_done;
  logic w_slot_load, w_shift_out, w_tx_accept;

  // cs_end wins over any sck edge in the same cycle, and sck is ignored
  // whenever the synchronized chip select is high.
  assign w_active    = (r_state != ST_IDLE) && !w_cs_end && !w_cs_level;
  assign w_rise_act  = w_sck_rise && w_active;
  assign w_fall_act  = w_sck_fall && w_active;
  assign w_byte_done = w_rise_act && (r_bit_cnt == BYTE_LAST_BIT);
  // A byte slot opens at select, and at the first falling edge after a
  // completed byte; other falling edges in a byte just advance miso.
  assign w_slot_load = w_cs_start || (w_fall_act && r_load_pending);
  assign w_shift_out = w_fall_act && !r_load_pending && (r_state == ST_SHIFTING);
  assign w_tx_accept = tx_data_valid && !r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_end) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_cs_start)  w_state_nxt = ST_SELECTED;
        ST_SELECTED: if (w_rise_act)  w_state_nxt = ST_SHIFTING;
        ST_SHIFTING: if (w_byte_done) w_state_nxt = ST_SELECTED;
        default:                      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Receive path and byte framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt      <= 3'd0;
      r_rx_shift     <= 7'd0;
      r_rx_data      <= 8'h00;
      r_rx_valid     <= 1'b0;
      r_rx_first     <= 1'b0;
      r_first_byte   <= 1'b0;
      r_load_pending <= 1'b0;
    end else begin
      r_rx_valid <= w_byte_done;
      if (w_rise_act) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= {r_rx_shift[5:0], w_mosi};
      end
      if (w_byte_done) begin
        r_rx_data    <= {r_rx_shift, w_mosi};
        r_rx_first   <= r_first_byte;
        r_first_byte <= 1'b0;
      end
      if (w_cs_start) begin
        r_bit_cnt      <= 3'd0;
        r_first_byte   <= 1'b1;
        r_load_pending <= 1'b0;
      end else if (w_cs_end || w_slot_load) begin
        r_load_pending <= 1'b0;
      end else if (w_byte_done) begin
        r_load_pending <= 1'b1;
      end
    end
  end

  // Transmit path. A tx_data_valid arriving in the slot-load cycle bypasses
  // the (empty) holding register and goes straight into the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift    <= 8'h00;
      r_hold_data   <= 8'h00;
      r_hold_full   <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= w_slot_load && !w_tx_accept && !r_hold_full;
      if (w_slot_load) begin
        if (w_tx_accept) begin
          r_tx_shift <= tx_data;
        end else if (r_hold_full) begin
          r_tx_shift  <= r_hold_data;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift <= IDLE_BYTE;
        end
      end else begin
        if (w_shift_out) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        if (w_tx_accept) begin
          r_hold_data <= tx_data;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign spi_miso      = (r_state != ST_IDLE) && r_tx_shift[7];
  assign rx_data_valid = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_first      = r_rx_first;
  assign tx_ready      = !r_hold_full;
  assign tx_underrun   = r_tx_underrun;
  assign cs_start      = w_cs_start;
  assign cs_end        = w_cs_end;

endmodule

// File: tb/tb_frontpanel_spi_responder.sv
// Testbench for frontpanel_spi_responder: a timed SPI mode-0 host drives
// bytes, a monitor logs rx strobes and pulse counts, and each test task
// compares against expectations computed from the transaction description.
module tb_frontpanel_spi_responder;
  import frontpanel_spi_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst, spi_sck, spi_cs_n, spi_mosi, tx_data_valid;
  logic [7:0] tx_data;
  logic       spi_miso, rx_data_valid, rx_first, tx_ready, tx_underrun, cs_start, cs_end;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  frontpanel_spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_first(rx_first), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .cs_start(cs_start), .cs_end(cs_end)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] rx_log[$];
  int n_under = 0, n_start = 0, n_end = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid) rx_log.push_back({rx_first, rx_data});
      if (tx_underrun) n_under++;
      if (cs_start) n_start++;
      if (cs_end) n_end++;
    end
  end

  // Host-side transaction description and captured miso bytes.
  logic [7:0] h_mosi[16];
  logic [7:0] h_txd[16];
  logic       h_txv[16];
  logic [7:0] h_miso[16];

  task automatic pulse_tx(input logic [7:0] d);
    tx_data = d;
    tx_data_valid = 1'b1;
    #10;
    tx_data_valid = 1'b0;
  endtask

  // Shifts n bytes with cs_n already low; sck period 80 ns (clk/8). cs_n is
  // released while sck is still high after the last bit.
  task automatic shift_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_mosi = h_mosi[k][i];
        #40;
        h_miso[k][i] = spi_miso;
        spi_sck = 1'b1;
        if (i == 4 && k + 1 < n && h_txv[k+1]) begin
          pulse_tx(h_txd[k+1]);
          #30;
        end else begin
          #40;
        end
        if (k == n - 1 && i == 0) begin
          spi_cs_n = 1'b1;
          #40;
        end
        spi_sck = 1'b0;
      end
    end
    #100;
  endtask

  task automatic run_xfer(input int n);
    @(negedge clk);
    if (h_txv[0]) pulse_tx(h_txd[0]);
    spi_cs_n = 1'b0;
    #80;
    shift_bytes(n);
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 16; k++) begin
      h_mosi[k] = 8'h00; h_txd[k] = 8'h00; h_txv[k] = 1'b0; h_miso[k] = 8'h00;
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data_valid = 1'b0; tx_data = 8'h00;
    repeat (4) @(negedge clk);
    got = {spi_miso, rx_data_valid, rx_first, tx_underrun, cs_start, cs_end, tx_ready, rx_data};
    vectors++;
    if (got !== {7'b0000001, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", got, {7'b0000001, 8'h00});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int base, u0;
    clear_plan();
    h_mosi[0] = 8'hA5; h_txv[0] = 1'b1; h_txd[0] = 8'h3C;
    base = rx_log.size(); u0 = n_under;
    run_xfer(1);
    vectors++;
    if (rx_log.size() - base != 1) begin
      miscompares++; $display("FAIL single_rx_count: got %0d want 1", rx_log.size() - base);
    end else begin
      vectors++;
      if (rx_log[base] !== {1'b1, 8'hA5}) begin
        miscompares++; $display("FAIL single_rx: got %h want %h", rx_log[base], {1'b1, 8'hA5});
      end
    end
    vectors++;
    if (h_miso[0] !== 8'h3C) begin
      miscompares++; $display("FAIL single_miso: got %h want 3c", h_miso[0]);
    end
    vectors++;
    if (n_under - u0 != 0) begin
      miscompares++; $display("FAIL single_underrun: got %0d want 0", n_under - u0);
    end
    vectors++;
    if (tx_ready !== 1'b1 || dut.r_state !== ST_IDLE) begin
      miscompares++; $display("FAIL single_idle: tx_ready %b state %0d want 1 0", tx_ready, dut.r_state);
    end
  endtask

  task automatic test_burst();
    int base, u0, s0, e0;
    clear_plan();
    h_mosi[0] = 8'h01; h_mosi[1] = 8'h02; h_mosi[2] = 8'h03;
    base = rx_log.size(); u0 = n_under; s0 = n_start; e0 = n_end;
    run_xfer(3);
    vectors++;
    if (rx_log.size() - base != 3) begin
      miscompares++; $display("FAIL burst_rx_count: got %0d want 3", rx_log.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rx_log[base+k] !== {k == 0, 8'(k + 1)}) begin
          miscompares++; $display("FAIL burst_rx%0d: got %h want %h", k, rx_log[base+k], {k == 0, 8'(k + 1)});
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (h_miso[k] !== 8'h00) begin
        miscompares++; $display("FAIL burst_miso%0d: got %h want 00", k, h_miso[k]);
      end
    end
    vectors++;
    if (n_under - u0 != 3 || n_start - s0 != 1 || n_end - e0 != 1) begin
      miscompares++;
      $display("FAIL burst_strobes: underrun/start/end got %0d/%0d/%0d want 3/1/1", n_under - u0, n_start - s0, n_end - e0);
    end
  endtask

  task automatic test_partial();
    int base, e0;
    logic [7:0] b;
    clear_plan();
    b = 8'hD6;
    base = rx_log.size(); e0 = n_end;
    @(negedge clk);
    spi_cs_n = 1'b0;
    #80;
    for (int i = 7; i >= 3; i--) begin
      spi_mosi = b[i]; #40; spi_sck = 1'b1; #40; spi_sck = 1'b0;
    end
    #40;
    spi_cs_n = 1'b1;
    #100;
    vectors++;
    if (rx_log.size() - base != 0) begin
      miscompares++; $display("FAIL partial_rx_count: got %0d want 0", rx_log.size() - base);
    end
    vectors++;
    if (n_end - e0 != 1) begin
      miscompares++; $display("FAIL partial_cs_end: got %0d want 1", n_end - e0);
    end
    vectors++;
    if (dut.r_state !== ST_IDLE || spi_miso !== 1'b0) begin
      miscompares++; $display("FAIL partial_idle: state %0d miso %b want 0 0", dut.r_state, spi_miso);
    end
    h_mosi[0] = 8'h5A;
    base = rx_log.size();
    run_xfer(1);
    vectors++;
    if (rx_log.size() - base != 1 || rx_log[base] !== {1'b1, 8'h5A}) begin
      miscompares++; $display("FAIL partial_next: count %0d entry %h want 1 15a", rx_log.size() - base, rx_log[base]);
    end
  endtask

  task automatic test_slot_collision();
    int base, u0;
    clear_plan();
    h_mosi[0] = 8'hC3;
    base = rx_log.size(); u0 = n_under;
    @(negedge clk);
    spi_cs_n = 1'b0;
    // cs_start strobe is high for the clk edge 35 ns after cs_n falls.
    #30;
    pulse_tx(8'h77);
    #40;
    shift_bytes(1);
    vectors++;
    if (h_miso[0] !== 8'h77) begin
      miscompares++; $display("FAIL collision_miso: got %h want 77", h_miso[0]);
    end
    vectors++;
    if (n_under - u0 != 0) begin
      miscompares++; $display("FAIL collision_underrun: got %0d want 0", n_under - u0);
    end
    vectors++;
    if (rx_log.size() - base != 1 || rx_log[base] !== {1'b1, 8'hC3}) begin
      miscompares++; $display("FAIL collision_rx: count %0d entry %h want 1 1c3", rx_log.size() - base, rx_log[base]);
    end
  endtask

  task automatic test_tx_ignored_when_full();
    int u0;
    clear_plan();
    h_mosi[0] = 8'h11; h_mosi[1] = 8'h22;
    u0 = n_under;
    @(negedge clk);
    pulse_tx(8'hAA);
    pulse_tx(8'hBB);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_tx_ready: got %b want 0", tx_ready);
    end
    spi_cs_n = 1'b0;
    #80;
    shift_bytes(2);
    vectors++;
    if (h_miso[0] !== 8'hAA || h_miso[1] !== 8'h00) begin
      miscompares++; $display("FAIL full_miso: got %h %h want aa 00", h_miso[0], h_miso[1]);
    end
    vectors++;
    if (n_under - u0 != 1) begin
      miscompares++; $display("FAIL full_underrun: got %0d want 1", n_under - u0);
    end
  endtask

  task automatic test_reset_midbyte();
    int base, s0;
    logic [14:0] got;
    logic [7:0] b;
    clear_plan();
    b = 8'hF0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    #80;
    for (int i = 7; i >= 4; i--) begin
      spi_mosi = b[i]; #40; spi_sck = 1'b1; #40; spi_sck = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {spi_miso, rx_data_valid, rx_first, tx_underrun, cs_start, cs_end, tx_ready, rx_data};
    vectors++;
    if (got !== {7'b0000001, 8'h00}) begin
      miscompares++; $display("FAIL midbyte_reset_outputs: got %b want %b", got, {7'b0000001, 8'h00});
    end
    rst = 1'b0;
    s0 = n_start;
    repeat (20) @(negedge clk);
    vectors++;
    if (n_start - s0 != 0 || spi_miso !== 1'b0) begin
      miscompares++; $display("FAIL midbyte_no_start: starts %0d miso %b want 0 0", n_start - s0, spi_miso);
    end
    spi_cs_n = 1'b1;
    #100;
    vectors++;
    if (n_start - s0 != 0) begin
      miscompares++; $display("FAIL midbyte_start_on_rise: got %0d want 0", n_start - s0);
    end
    h_mosi[0] = 8'h96; h_txv[0] = 1'b1; h_txd[0] = 8'hE1;
    base = rx_log.size();
    run_xfer(1);
    vectors++;
    if (n_start - s0 != 1 || h_miso[0] !== 8'hE1) begin
      miscompares++; $display("FAIL midbyte_next: starts %0d miso %h want 1 e1", n_start - s0, h_miso[0]);
    end
    vectors++;
    if (rx_log.size() - base != 1 || rx_log[base] !== {1'b1, 8'h96}) begin
      miscompares++; $display("FAIL midbyte_next_rx: count %0d entry %h want 1 196", rx_log.size() - base, rx_log[base]);
    end
  endtask

  task automatic test_random();
    int total, n, base, u0, exp_under;
    logic [7:0] exp_miso;
    total = 0;
    while (total < 256) begin
      n = int'($urandom_range(1, 8));
      if (n > 256 - total) n = 256 - total;
      clear_plan();
      exp_under = 0;
      for (int k = 0; k < n; k++) begin
        h_mosi[k] = 8'($urandom);
        h_txv[k]  = 1'($urandom);
        h_txd[k]  = 8'($urandom);
        if (!h_txv[k]) exp_under++;
      end
      base = rx_log.size(); u0 = n_under;
      run_xfer(n);
      vectors++;
      if (rx_log.size() - base != n) begin
        miscompares++; $display("FAIL rand_rx_count: got %0d want %0d", rx_log.size() - base, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          vectors++;
          if (rx_log[base+k] !== {k == 0, h_mosi[k]}) begin
            miscompares++; $display("FAIL rand_rx byte %0d: got %h want %h", total + k, rx_log[base+k], {k == 0, h_mosi[k]});
          end
        end
      end
      for (int k = 0; k < n; k++) begin
        exp_miso = h_txv[k] ? h_txd[k] : 8'h00;
        vectors++;
        if (h_miso[k] !== exp_miso) begin
          miscompares++; $display("FAIL rand_miso byte %0d: got %h want %h", total + k, h_miso[k], exp_miso);
        end
      end
      vectors++;
      if (n_under - u0 != exp_under) begin
        miscompares++; $display("FAIL rand_underrun: got %0d want %0d", n_under - u0, exp_under);
      end
      total += n;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_partial();
    test_slot_collision();
    test_tx_ignored_when_full();
    test_reset_midbyte();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
